// File: rtl/reset_sequencer_n_if.sv
// Request/reset-output bundle for reset_sequencer_n.
// The master issues reset requests and the slave drives the staged active-low resets.
interface reset_sequencer_n_if #(
    parameter int unsigned N_OUT = 4
);
    logic             I_req;
    logic [N_OUT-1:0] O_rstn;
    logic             O_busy;
    logic             O_done;

    modport master (output I_req, input O_rstn, input O_busy, input O_done);
    modport slave  (input I_req, output O_rstn, output O_busy, output O_done);
endinterface

// File: rtl/reset_sequencer_n.sv
// Staged reset release: hold every active-low output low, then release them LSB first
// at fixed intervals. A request or RESET restarts the whole sequence.
module reset_sequencer_n #(
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    reset_sequencer_n_if.slave  bus
);
    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned STG_W   = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [STG_W-1:0] stage_q, stage_n;
    logic [N_OUT-1:0] rstn_q, rstn_n;
    logic             done_q, done_n;
    logic             busy_q;

    logic hold_hit;
    logic step_hit;
    logic last_stage;

    assign hold_hit   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign step_hit   = (cnt_q == CNT_W'(STEP_CYCLES - 1));
    assign last_stage = (stage_q == STG_W'(N_OUT - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ASSERT;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; a request overrides everything except RESET
    always_comb begin
        state_n = state_q;
        if (bus.I_req) begin
            state_n = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (hold_hit) begin
                        state_n = (N_OUT == 1) ? ST_DONE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (step_hit && last_stage) begin
                        state_n = ST_DONE;
                    end
                end
                ST_DONE:  state_n = ST_DONE;
                default:  state_n = ST_ASSERT;
            endcase
        end
    end

    // Next values of counter, stage index and the registered outputs
    always_comb begin
        cnt_n   = cnt_q;
        stage_n = stage_q;
        rstn_n  = rstn_q;
        if (bus.I_req) begin
            cnt_n   = '0;
            stage_n = '0;
            rstn_n  = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rstn_n = '0;
                    if (hold_hit) begin
                        cnt_n     = '0;
                        rstn_n[0] = 1'b1;
                        stage_n   = STG_W'(1);
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (step_hit) begin
                        cnt_n   = '0;
                        stage_n = stage_q + STG_W'(1);
                        // Release exactly the bit addressed by the current stage
                        for (int k = 0; k < N_OUT; k++) begin
                            if (stage_q == STG_W'(k)) begin
                                rstn_n[k] = 1'b1;
                            end
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_n = cnt_q;
                end
            endcase
        end
        done_n = (state_n == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            stage_q <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_n;
            stage_q <= stage_n;
            rstn_q  <= rstn_n;
            done_q  <= done_n;
            busy_q  <= ~done_n;
        end
    end

    assign bus.O_rstn = rstn_q;
    assign bus.O_done = done_q;
    assign bus.O_busy = busy_q;
endmodule

// File: tb/tb_reset_sequencer_n.sv
// Directed bench for reset_sequencer_n (N_OUT=4, HOLD=16, STEP=4): power-up, requests,
// collisions and RESET in DONE, plus per-cycle invariant checks.
module tb_reset_sequencer_n;
    localparam int unsigned N = 4;
    localparam int unsigned H = 16;
    localparam int unsigned S = 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    reset_sequencer_n_if #(.N_OUT(N)) bus ();

    reset_sequencer_n #(
        .N_OUT      (N),
        .HOLD_CYCLES(H),
        .STEP_CYCLES(S)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Expected outputs t edges after counting (re)started: bit k rises at t = H + k*S
    function automatic logic [N-1:0] exp_rstn(input int t);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (t >= int'(H + k * S)) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic exp_done(input int t);
        return (t >= int'(H + (N - 1) * S));
    endfunction

    // Invariants sampled every cycle on the falling edge
    always @(negedge CLK) begin
        logic [N-1:0] inc;
        if (armed) begin
            inc = bus.O_rstn + N'(1);
            checks++;
            if ((bus.O_rstn & inc) !== '0) begin
                errors++;
                $display("FAIL prefix t=%0t: rstn %b is not an LSB-first prefix", $time, bus.O_rstn);
            end
            checks++;
            if (bus.O_busy !== ~bus.O_done) begin
                errors++;
                $display("FAIL busy_vs_done t=%0t: busy %b done %b", $time, bus.O_busy, bus.O_done);
            end
            checks++;
            if (bus.O_done !== (bus.O_rstn == {N{1'b1}})) begin
                errors++;
                $display("FAIL done_vs_rstn t=%0t: done %b rstn %b", $time, bus.O_done, bus.O_rstn);
            end
        end
    end

    task automatic do_reset(input int n);
        RESET     = 1'b1;
        bus.I_req = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
        armed = 1'b1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        bus.I_req = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        armed = 1'b1;
        checks++;
        if (bus.O_rstn !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rstn: got %b expected 0000", bus.O_rstn);
        end
        checks++;
        if (bus.O_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 1", bus.O_busy);
        end
        checks++;
        if (bus.O_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", bus.O_done);
        end
        bus.I_req = 1'b0;
    endtask

    task automatic test_powerup();
        int base;
        logic [N-1:0] er;
        do_reset(3);
        base = 0;
        for (int e = 1; e <= 34; e++) begin
            @(posedge CLK);
            #1;
            er = exp_rstn(e - base);
            checks++;
            if (bus.O_rstn !== er) begin
                errors++;
                $display("FAIL powerup_rstn edge %0d: got %b expected %b", e, bus.O_rstn, er);
            end
            checks++;
            if (bus.O_done !== exp_done(e - base)) begin
                errors++;
                $display("FAIL powerup_done edge %0d: got %b expected %b", e, bus.O_done, exp_done(e - base));
            end
        end
    endtask

    task automatic test_mid_release();
        int base;
        logic [N-1:0] er;
        do_reset(3);
        base = 0;
        for (int e = 1; e <= 54; e++) begin
            bus.I_req = (e == 22);
            if (e == 22) base = e;
            @(posedge CLK);
            #1;
            er = exp_rstn(e - base);
            checks++;
            if (bus.O_rstn !== er) begin
                errors++;
                $display("FAIL mid_release_rstn edge %0d: got %b expected %b", e, bus.O_rstn, er);
            end
            checks++;
            if (bus.O_done !== exp_done(e - base)) begin
                errors++;
                $display("FAIL mid_release_done edge %0d: got %b expected %b", e, bus.O_done, exp_done(e - base));
            end
        end
        bus.I_req = 1'b0;
    endtask

    task automatic test_held_req();
        int base;
        logic [N-1:0] er;
        do_reset(3);
        base = 0;
        for (int e = 1; e <= 72; e++) begin
            bus.I_req = (e >= 5 && e <= 40);
            if (bus.I_req) base = e;
            @(posedge CLK);
            #1;
            er = exp_rstn(e - base);
            checks++;
            if (bus.O_rstn !== er) begin
                errors++;
                $display("FAIL held_req_rstn edge %0d: got %b expected %b", e, bus.O_rstn, er);
            end
            checks++;
            if (bus.O_done !== exp_done(e - base)) begin
                errors++;
                $display("FAIL held_req_done edge %0d: got %b expected %b", e, bus.O_done, exp_done(e - base));
            end
        end
        bus.I_req = 1'b0;
    endtask

    task automatic test_collision();
        int base;
        logic [N-1:0] er;
        do_reset(3);
        base = 0;
        for (int e = 1; e <= 52; e++) begin
            bus.I_req = (e == 20);
            if (e == 20) base = e;
            @(posedge CLK);
            #1;
            er = exp_rstn(e - base);
            checks++;
            if (bus.O_rstn !== er) begin
                errors++;
                $display("FAIL collision_rstn edge %0d: got %b expected %b", e, bus.O_rstn, er);
            end
            checks++;
            if (bus.O_busy !== ~exp_done(e - base)) begin
                errors++;
                $display("FAIL collision_busy edge %0d: got %b expected %b", e, bus.O_busy, ~exp_done(e - base));
            end
        end
        bus.I_req = 1'b0;
    endtask

    task automatic test_reset_in_done();
        int base;
        logic [N-1:0] er;
        do_reset(3);
        base = 0;
        for (int e = 1; e <= 74; e++) begin
            RESET = (e == 40);
            if (e == 40) base = e;
            @(posedge CLK);
            #1;
            er = exp_rstn(e - base);
            checks++;
            if (bus.O_rstn !== er) begin
                errors++;
                $display("FAIL reset_in_done_rstn edge %0d: got %b expected %b", e, bus.O_rstn, er);
            end
            checks++;
            if (bus.O_done !== exp_done(e - base)) begin
                errors++;
                $display("FAIL reset_in_done_done edge %0d: got %b expected %b", e, bus.O_done, exp_done(e - base));
            end
        end
        RESET = 1'b0;
    endtask

    initial begin
        bus.I_req = 1'b0;
        test_reset();
        test_powerup();
        test_mid_release();
        test_held_req();
        test_collision();
        test_reset_in_done();
        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer_n.md
RESET_SEQUENCER_N -- requirements
Module: reset_sequencer_n

Interface
REQ-001 Parameter N_OUT, default 4: number of active-low reset outputs; legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted before the first release; minimum 1.
REQ-003 Parameter STEP_CYCLES, default 4: cycles between successive output releases; minimum 1.
REQ-004 Port CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port RESET  in  1  synchronous, active-high reset.
REQ-006 Port I_req  in  1  synchronous reset request; level-sampled each cycle.
REQ-007 Port O_rstn  out  N_OUT  active-low reset outputs feeding downstream AsyncResetN domains; bit k is released k-th.
REQ-008 Port O_busy  out  1  high while any O_rstn bit is asserted (0).
REQ-009 Port O_done  out  1  high when all O_rstn bits are released (1).
REQ-010 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Function
REQ-011 The FSM SHALL have exactly three states: ASSERT, RELEASE and DONE.
REQ-012 Counter width SHALL be clog2(max(HOLD_CYCLES, STEP_CYCLES)+1); stage index width SHALL be clog2(N_OUT+1).
REQ-013 In ASSERT: O_rstn = all 0, counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1 and I_req=0, the block SHALL set O_rstn[0]=1, clear the counter, set stage=1 and enter RELEASE (or DONE if N_OUT=1).
REQ-014 In RELEASE: counter increments each cycle.
  - When the counter reaches STEP_CYCLES-1, the block SHALL set O_rstn[stage]=1, clear the counter and increment stage.
  - When that release sets the last bit, N_OUT-1, the block SHALL enter DONE.
REQ-015 Release timing: counting edges after RESET falls, edge 1 being the first with RESET=0, O_rstn[k] SHALL rise at edge HOLD_CYCLES + k*STEP_CYCLES.
REQ-016 Release ordering: released bits SHALL always form a contiguous LSB-first prefix; bit k SHALL never be 1 while bit j<k is 0.
REQ-017 O_done SHALL rise on the same edge as O_rstn[N_OUT-1].
REQ-018 O_busy SHALL equal NOT O_done at all times.
REQ-019 I_req=1 in any state SHALL, at that edge: set O_rstn = all 0, clear counter and stage, clear O_done, and enter or remain in ASSERT.
REQ-020 I_req held high SHALL keep the block in ASSERT with the counter at 0; the hold interval SHALL start counting on the first edge where I_req=0.
REQ-021 I_req=1 on the same edge as a scheduled release SHALL win; no bit is released on that edge.
REQ-022 The counter SHALL never exceed max(HOLD_CYCLES, STEP_CYCLES)-1, and stage SHALL never exceed N_OUT.
REQ-023 In DONE, state and outputs SHALL hold indefinitely until I_req or RESET.

Reset
REQ-024 RESET=1 at an edge SHALL set state=ASSERT, counter=0, stage=0, O_rstn=all 0, O_busy=1 and O_done=0.
REQ-025 RESET SHALL take priority over I_req and over any scheduled release.
REQ-026 RESET asserted mid-RELEASE or in DONE SHALL re-assert all outputs on that edge.
REQ-027 After RESET falls, the sequence SHALL restart per REQ-015.

Verification (N_OUT=4, HOLD=16, STEP=4)
REQ-028 Power-up: RESET high 3 cycles, then low -> O_rstn steps 0000 -> 0001 at edge 16, 0011 at 20, 0111 at 24, 1111 at 28; O_done=1 from edge 28; O_busy=0 from edge 28.
REQ-029 Mid-release request: I_req=1 for one cycle at edge 22 (O_rstn=0011) -> O_rstn=0000 at edge 22; bit0 re-releases at edge 38 and O_done=1 at edge 50.
REQ-030 Held request: I_req high for edges 5..40 -> O_rstn=0000 throughout; bit0 rises at edge 56.
REQ-031 Collision: I_req=1 exactly at edge 20 -> O_rstn stays 0000 (bit1 not released) and no bit0 retained; sequence restarts from ASSERT.
REQ-032 Reset in DONE: RESET pulse at edge 40 -> O_rstn=0000, O_done=0 at edge 40; full sequence repeats relative to RESET deassertion.
REQ-033 Continuous checkers on every cycle: contiguous-prefix property (REQ-016), O_busy == !O_done, and O_done == (O_rstn == all 1s).
